// File: rtl/spi_tx_queue_if.sv
// Handshake bundle shared by the CPU write port, the transmit queue and the SPI serializer.
// The slave modport is the queue; the master modport is whatever drives it.
interface spi_tx_queue_if #(
    parameter int W_DATA = 32,
    parameter int W_PTR  = 2
);
    logic              wr_en;
    logic [W_DATA-1:0] wr_data;
    logic              clr_overflow;
    logic              full;
    logic              empty;
    logic [W_PTR:0]    count;
    logic              overflow;
    logic              tx_ready;
    logic [W_DATA-1:0] tx_data;
    logic              tx_valid;

    modport master (
        output wr_en, wr_data, clr_overflow, tx_ready,
        input  full, empty, count, overflow, tx_data, tx_valid
    );

    modport slave (
        input  wr_en, wr_data, clr_overflow, tx_ready,
        output full, empty, count, overflow, tx_data, tx_valid
    );
endinterface

// File: rtl/spi_tx_queue.sv
// Circular transmit FIFO feeding an SPI serializer through a launch/ack/busy handshake.
// The popped word is held in tx_data until the serializer has finished shifting it out.
module spi_tx_queue #(
    parameter int W_DATA = 32,
    parameter int DEPTH  = 4,
    parameter int W_PTR  = 2
) (
    input  logic          clk,
    input  logic          rst,
    spi_tx_queue_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_ACK,
        S_BUSY
    } state_t;

    localparam logic [W_PTR:0] C_DEPTH = (W_PTR+1)'(DEPTH);

    state_t            r_state;
    state_t            w_next_state;
    logic [W_DATA-1:0] r_mem [DEPTH];
    logic [W_PTR-1:0]  r_wr_ptr;
    logic [W_PTR-1:0]  r_rd_ptr;
    logic [W_PTR:0]    r_count;
    logic              r_overflow;
    logic [W_DATA-1:0] r_tx_data;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;

    // Flags come only from the registered count, so wr_en never reaches them combinationally.
    assign w_full  = (r_count == C_DEPTH);
    assign w_empty = (r_count == '0);
    assign w_push  = bus.wr_en && (!w_full || w_pop);
    assign w_drop  = bus.wr_en && w_full && !w_pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty && bus.tx_ready) begin
                    w_pop        = 1'b1;
                    w_next_state = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                w_next_state = S_ACK;
            end
            S_ACK: begin
                if (!bus.tx_ready) begin
                    w_next_state = S_BUSY;
                end
            end
            S_BUSY: begin
                if (bus.tx_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Storage needs no reset: the pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // A dropped write outranks a clear arriving in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overflow <= 1'b0;
            r_tx_data  <= '0;
        end else begin
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (bus.clr_overflow) begin
                r_overflow <= 1'b0;
            end
            if (w_pop) begin
                r_tx_data <= r_mem[r_rd_ptr];
            end
        end
    end

    assign bus.full     = w_full;
    assign bus.empty    = w_empty;
    assign bus.count    = r_count;
    assign bus.overflow = r_overflow;
    assign bus.tx_data  = r_tx_data;
    assign bus.tx_valid = (r_state == S_LAUNCH);
endmodule
